// File: rtl/button_deb_multi.sv
// N-channel button debouncer sharing one 1 ms prescaler.
// Each channel provides a debounced level, press/release/long-press pulses and a clearable toggle.
module button_deb_multi #(
  parameter int NB_BUTTONS      = 4,
  parameter int CLK_FREQ        = 95000,
  parameter int DEBOUNCE_PER_MS = 20,
  parameter int LONG_PRESS_MS   = 1000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NB_BUTTONS-1:0] button_in,
  input  logic [NB_BUTTONS-1:0] toggle_clr,
  output logic [NB_BUTTONS-1:0] btn_level,
  output logic [NB_BUTTONS-1:0] btn_press,
  output logic [NB_BUTTONS-1:0] btn_release,
  output logic [NB_BUTTONS-1:0] btn_long,
  output logic [NB_BUTTONS-1:0] btn_toggle
);

  localparam int PW = $clog2(CLK_FREQ);
  localparam int DW = $clog2(DEBOUNCE_PER_MS + 1);
  localparam int LW = $clog2(LONG_PRESS_MS + 1);

  localparam logic [PW-1:0] P_LAST = PW'(CLK_FREQ - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_PER_MS - 1);
  localparam logic [LW-1:0] L_MAX  = LW'(LONG_PRESS_MS);

  logic [PW-1:0]         r_pcnt;
  logic                  w_tick;
  logic [NB_BUTTONS-1:0] r_s1;
  logic [NB_BUTTONS-1:0] r_s2;

  assign w_tick = (r_pcnt == P_LAST);

  // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PW'(1);
    end
  end

  // Two-flop synchroniser; polarity is normalised so 1 always means pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= button_in ^ {NB_BUTTONS{ACTIVE_LOW}};
      r_s2 <= r_s1;
    end
  end

  for (genvar g = 0; g < NB_BUTTONS; g++) begin : g_ch
    logic [DW-1:0] r_dcnt;
    logic [LW-1:0] r_lcnt;
    logic [LW-1:0] w_lcnt_inc;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic          r_toggle;

    assign w_lcnt_inc = r_lcnt + LW'(1);

    // Any cycle where the synchronised pin matches the level restarts the stable-time count.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_dcnt    <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        if (r_s2[g] == r_level) begin
          r_dcnt <= '0;
        end else if (w_tick) begin
          if (r_dcnt == D_LAST) begin
            r_dcnt    <= '0;
            r_level   <= r_s2[g];
            r_press   <= r_s2[g];
            r_release <= ~r_s2[g];
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
      end
    end

    // Hold counter saturates, so a single hold yields at most one long pulse.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_lcnt <= '0;
        r_long <= 1'b0;
      end else begin
        r_long <= 1'b0;
        if (!r_level) begin
          r_lcnt <= '0;
        end else if (w_tick && (r_lcnt < L_MAX)) begin
          r_lcnt <= w_lcnt_inc;
          r_long <= (w_lcnt_inc == L_MAX);
        end
      end
    end

    // Clear wins over a press arriving in the same cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_toggle <= 1'b0;
      end else if (toggle_clr[g]) begin
        r_toggle <= 1'b0;
      end else if (r_press) begin
        r_toggle <= ~r_toggle;
      end
    end

    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_release;
    assign btn_long[g]    = r_long;
    assign btn_toggle[g]  = r_toggle;
  end : g_ch

endmodule

// File: tb/tb_button_deb_multi.sv
// Self-checking bench for button_deb_multi: table of hold/bounce windows plus
// hand-written sequences for exact latencies, clear race and reset mid-debounce.
module tb_button_deb_multi;

  localparam int NB  = 4;
  localparam int CF  = 10;
  localparam int DEB = 3;
  localparam int LP  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] button_in;
  logic [NB-1:0] toggle_clr;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_long;
  logic [NB-1:0] btn_toggle;

  always #5 clk = ~clk;

  button_deb_multi #(
    .NB_BUTTONS     (NB),
    .CLK_FREQ       (CF),
    .DEBOUNCE_PER_MS(DEB),
    .LONG_PRESS_MS  (LP),
    .ACTIVE_LOW     (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button_in  (button_in),
    .toggle_clr (toggle_clr),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .btn_toggle (btn_toggle)
  );

  typedef struct {
    logic [NB-1:0] btn;
    logic [NB-1:0] clr;
    int            ncyc;
    logic [NB-1:0] lvl;
    logic [NB-1:0] tog;
    logic [7:0]    prs;   // 2-bit pulse count per channel, saturating at 3
    logic [7:0]    rel;
    logic [7:0]    lng;
  } vec_t;

  vec_t tbl[14];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;   // edges since the last reset edge

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Edge on which a change driven just after edge a is committed: the synchroniser
  // exposes it from edge a+3, then DEB ticks (ticks fall on multiples of CF) are needed.
  function automatic int commit_cyc(input int a);
    int t;
    t = a + 3;
    while (t % CF != 0) t++;
    return t + (DEB - 1) * CF;
  endfunction

  function automatic logic [1:0] sat2(input int c);
    return (c > 3) ? 2'd3 : 2'(c);
  endfunction

  // kind: 0 press, 1 release, 2 long. Returns -1 when the bound expires.
  task automatic wait_pulse(input int ch, input int kind, input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound; k++) begin
      step();
      if ((kind == 0 && btn_press[ch]) || (kind == 1 && btn_release[ch]) ||
          (kind == 2 && btn_long[ch])) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic run_window(input vec_t v, input int idx);
    int            pc[NB];
    int            rc[NB];
    int            lc[NB];
    logic [NB-1:0] both;
    logic [7:0]    p;
    logic [7:0]    r;
    logic [7:0]    l;
    for (int i = 0; i < NB; i++) begin
      pc[i] = 0;
      rc[i] = 0;
      lc[i] = 0;
    end
    both       = '0;
    button_in  = v.btn;
    toggle_clr = v.clr;
    repeat (v.ncyc) begin
      step();
      for (int i = 0; i < NB; i++) begin
        if (btn_press[i])   pc[i]++;
        if (btn_release[i]) rc[i]++;
        if (btn_long[i])    lc[i]++;
      end
      both |= btn_press & btn_release;
    end
    for (int i = 0; i < NB; i++) begin
      p[2*i +: 2] = sat2(pc[i]);
      r[2*i +: 2] = sat2(rc[i]);
      l[2*i +: 2] = sat2(lc[i]);
    end
    check($sformatf("vec%0d level", idx),        32'(btn_level),  32'(v.lvl));
    check($sformatf("vec%0d toggle", idx),       32'(btn_toggle), 32'(v.tog));
    check($sformatf("vec%0d press count", idx),  32'(p),          32'(v.prs));
    check($sformatf("vec%0d release count", idx), 32'(r),         32'(v.rel));
    check($sformatf("vec%0d long count", idx),   32'(l),          32'(v.lng));
    check($sformatf("vec%0d press&release", idx), 32'(both),      32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int at;
    int a;
    int t1;
    logic [NB-1:0] early;

    // Bounce on ch1: 12-cycle segments never span three ticks, then a clean hold.
    tbl[0]  = '{4'b0010, 4'b0000,  12, 4'b0000, 4'b0001, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{4'b0000, 4'b0000,  12, 4'b0000, 4'b0001, 8'h00, 8'h00, 8'h00};
    tbl[2]  = '{4'b0010, 4'b0000,  12, 4'b0000, 4'b0001, 8'h00, 8'h00, 8'h00};
    tbl[3]  = '{4'b0000, 4'b0000,  12, 4'b0000, 4'b0001, 8'h00, 8'h00, 8'h00};
    tbl[4]  = '{4'b0010, 4'b0000,  12, 4'b0000, 4'b0001, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{4'b0000, 4'b0000,  12, 4'b0000, 4'b0001, 8'h00, 8'h00, 8'h00};
    tbl[6]  = '{4'b0010, 4'b0000,  12, 4'b0000, 4'b0001, 8'h00, 8'h00, 8'h00};
    tbl[7]  = '{4'b0000, 4'b0000,  12, 4'b0000, 4'b0001, 8'h00, 8'h00, 8'h00};
    tbl[8]  = '{4'b0010, 4'b0000,  40, 4'b0010, 4'b0011, 8'h04, 8'h00, 8'h00};
    tbl[9]  = '{4'b0000, 4'b0000,  40, 4'b0000, 4'b0011, 8'h00, 8'h04, 8'h00};
    // Long hold on ch2: one long pulse, no repeat, then release.
    tbl[10] = '{4'b0100, 4'b0000, 150, 4'b0100, 4'b0111, 8'h10, 8'h00, 8'h10};
    tbl[11] = '{4'b0000, 4'b0000,  40, 4'b0000, 4'b0111, 8'h00, 8'h10, 8'h00};
    // Simultaneous ch0+ch3, then release while clearing toggles of ch1 and ch3.
    tbl[12] = '{4'b1001, 4'b0000,  40, 4'b1001, 4'b1110, 8'h41, 8'h00, 8'h00};
    tbl[13] = '{4'b0000, 4'b1010,  40, 4'b0000, 4'b0100, 8'h00, 8'h41, 8'h00};

    // Reset with all pins high; outputs must read 0.
    rst        = 1'b1;
    button_in  = 4'hF;
    toggle_clr = '0;
    repeat (3) step();
    check("reset outputs", {btn_level, btn_press, btn_release, btn_long, btn_toggle}, 32'd0);

    // Clean press on ch0 driven at release; exact commit edge proves the first tick.
    button_in = 4'b0001;
    rst       = 1'b0;
    cyc       = 0;
    wait_pulse(0, 0, 40, at);
    check("ch0 press cycle", at, commit_cyc(0));
    check("ch0 level after press", 32'(btn_level), 32'b0001);
    step();
    check("ch0 press width", 32'(btn_press), 32'd0);
    check("ch0 toggle after press", 32'(btn_toggle), 32'b0001);
    a = cyc;
    button_in = 4'b0000;
    wait_pulse(0, 1, 40, at);
    check("ch0 release cycle", at, commit_cyc(a));
    check("ch0 level after release", 32'(btn_level), 32'd0);

    for (int i = 0; i < 14; i++) run_window(tbl[i], i);
    toggle_clr = '0;

    // Clear asserted in the very cycle btn_press[3] is high.
    a = cyc;
    button_in = 4'b1000;
    wait_pulse(3, 0, 40, at);
    check("ch3 press cycle", at, commit_cyc(a));
    toggle_clr = 4'b1000;
    step();
    check("ch3 toggle after clear race", 32'(btn_toggle), 32'b0100);
    toggle_clr = '0;
    step();
    check("ch3 toggle stays cleared", 32'(btn_toggle), 32'b0100);
    a = cyc;
    button_in = 4'b0000;
    wait_pulse(3, 1, 40, at);
    check("ch3 release cycle", at, commit_cyc(a));

    // Reset two ticks into a ch0 press: pending count discarded, restart commits normally.
    a = cyc;
    button_in = 4'b0001;
    t1 = commit_cyc(a) - (DEB - 1) * CF;
    early = '0;
    while (cyc < t1 + CF) begin
      step();
      early |= btn_press;
    end
    check("no press before mid-debounce reset", 32'(early), 32'd0);
    rst = 1'b1;
    repeat (2) step();
    check("mid-debounce reset outputs",
          {btn_level, btn_press, btn_release, btn_long, btn_toggle}, 32'd0);
    rst = 1'b0;
    cyc = 0;
    wait_pulse(0, 0, 40, at);
    check("ch0 press after reset", at, commit_cyc(0));
    step();
    check("ch0 toggle after reset press", 32'(btn_toggle), 32'b0001);

    // Exact long-press timing on ch2: LP ticks after the commit edge.
    a = cyc;
    button_in = 4'b0101;
    wait_pulse(2, 0, 40, at);
    check("ch2 press cycle", at, commit_cyc(a));
    t1 = at;
    wait_pulse(2, 2, 120, at);
    check("ch2 long cycle", at, t1 + LP * CF);
    a = cyc;
    button_in = 4'b0001;
    wait_pulse(2, 1, 40, at);
    check("ch2 release cycle", at, commit_cyc(a));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
